// File: rtl/c17_bist_pkg.sv
// rtl/c17_bist_pkg.sv - shared encodings, widths and tap constants for the c17 BIST controller
package c17_bist_pkg;

    localparam int MISR_W = 8;
    localparam int LFSR_W = 5;
    localparam int CNT_W  = 6;

    // Feedback taps: MISR uses bits 7,5,4,3; LFSR is x^5+x^3+1 (bits 4,2).
    localparam logic [MISR_W-1:0] MISR_TAPS = 8'hB8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 5'b10100;

    // RUN and COMPARE share bit 0 so busy is a single register bit.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_COMPARE = 2'b11,
        ST_DONE    = 2'b10
    } state_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] p,
                                                    input logic [LFSR_W-1:0] seed);
        if (p == '0) return seed;
        return {p[LFSR_W-2:0], ^(p & LFSR_TAPS)};
    endfunction

    function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] m,
                                                    input logic [1:0]        resp);
        return {m[MISR_W-2:0], ^(m & MISR_TAPS)} ^ {{(MISR_W-2){1'b0}}, resp};
    endfunction

endpackage

// File: rtl/c17_bist_if.sv
// rtl/c17_bist_if.sv - run control and result bundle between a BIST master and the controller
interface c17_bist_if;
    import c17_bist_pkg::*;

    logic              start;
    logic              abort;
    logic [MISR_W-1:0] golden_sig;
    logic              busy;
    logic              done;
    logic              pass;
    logic [MISR_W-1:0] signature;
    logic [LFSR_W-1:0] pattern;

    modport master (
        output start, abort, golden_sig,
        input  busy, done, pass, signature, pattern
    );

    modport slave (
        input  start, abort, golden_sig,
        output busy, done, pass, signature, pattern
    );

endinterface

// File: rtl/c17_bist_ctrl_c17.sv
// rtl/c17_bist_ctrl_c17.sv - ISCAS-85 c17 benchmark netlist, six NAND gates
module c17 (
    input  logic n1_i,
    input  logic n2_i,
    input  logic n3_i,
    input  logic n6_i,
    input  logic n7_i,
    output logic n22_o,
    output logic n23_o
);

    logic n10, n11, n16, n19;

    assign n10   = ~(n1_i & n3_i);
    assign n11   = ~(n3_i & n6_i);
    assign n16   = ~(n2_i & n11);
    assign n19   = ~(n11 & n7_i);
    assign n22_o = ~(n10 & n16);
    assign n23_o = ~(n16 & n19);

endmodule

// File: rtl/c17_bist_ctrl.sv
// rtl/c17_bist_ctrl.sv - LFSR-driven self test of c17 with MISR compaction and golden compare
module c17_bist_ctrl
    import c17_bist_pkg::*;
#(
    parameter int                N_PAT = 32,
    parameter logic [LFSR_W-1:0] SEED  = 5'b00001
) (
    input  logic      clk,
    input  logic      rst_n,
    c17_bist_if.slave bist
);

    state_e            state_q;
    logic [LFSR_W-1:0] pat_q,  pat_d;
    logic [MISR_W-1:0] misr_q, misr_d;
    logic [MISR_W-1:0] golden_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              done_q;
    logic              pass_q;
    logic              o22, o23;

    c17 u_c17 (
        .n1_i  (pat_q[0]),
        .n2_i  (pat_q[1]),
        .n3_i  (pat_q[2]),
        .n6_i  (pat_q[3]),
        .n7_i  (pat_q[4]),
        .n22_o (o22),
        .n23_o (o23)
    );

    assign pat_d  = lfsr_next(pat_q, SEED);
    assign misr_d = misr_next(misr_q, {o23, o22});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pat_q    <= '0;
            misr_q   <= '0;
            golden_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bist.start && !bist.abort) begin
                        state_q  <= ST_RUN;
                        pat_q    <= '0;
                        misr_q   <= '0;
                        cnt_q    <= '0;
                        golden_q <= bist.golden_sig;
                        pass_q   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // An aborted run leaves the MISR untouched for inspection.
                    if (bist.abort) begin
                        state_q <= ST_IDLE;
                        pass_q  <= 1'b0;
                    end else begin
                        misr_q <= misr_d;
                        pat_q  <= pat_d;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(N_PAT - 1)) state_q <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (bist.abort) begin
                        state_q <= ST_IDLE;
                        pass_q  <= 1'b0;
                    end else begin
                        pass_q  <= (misr_q == golden_q);
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bist.busy      = state_q[0];
    assign bist.done      = done_q;
    assign bist.pass      = pass_q;
    assign bist.signature = misr_q;
    assign bist.pattern   = pat_q;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// tb/tb_c17_bist_ctrl.sv - randomized self-checking bench for c17_bist_ctrl at N_PAT = 1, 3, 32
module tb_c17_bist_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    c17_bist_if if0 ();
    c17_bist_if if1 ();
    c17_bist_if if2 ();

    c17_bist_ctrl #(.N_PAT(1))  u_dut0 (.clk(clk), .rst_n(rst_n), .bist(if0));
    c17_bist_ctrl #(.N_PAT(3))  u_dut1 (.clk(clk), .rst_n(rst_n), .bist(if1));
    c17_bist_ctrl #(.N_PAT(32)) u_dut2 (.clk(clk), .rst_n(rst_n), .bist(if2));

    logic       start_a [3];
    logic       abort_a [3];
    logic [7:0] gold_a  [3];
    logic       busy_a  [3];
    logic       done_a  [3];
    logic       pass_a  [3];
    logic [7:0] sig_a   [3];
    logic [4:0] pat_a   [3];

    assign if0.start = start_a[0];  assign if0.abort = abort_a[0];  assign if0.golden_sig = gold_a[0];
    assign if1.start = start_a[1];  assign if1.abort = abort_a[1];  assign if1.golden_sig = gold_a[1];
    assign if2.start = start_a[2];  assign if2.abort = abort_a[2];  assign if2.golden_sig = gold_a[2];

    assign busy_a[0] = if0.busy;  assign done_a[0] = if0.done;  assign pass_a[0] = if0.pass;
    assign busy_a[1] = if1.busy;  assign done_a[1] = if1.done;  assign pass_a[1] = if1.pass;
    assign busy_a[2] = if2.busy;  assign done_a[2] = if2.done;  assign pass_a[2] = if2.pass;
    assign sig_a[0]  = if0.signature;  assign pat_a[0] = if0.pattern;
    assign sig_a[1]  = if1.signature;  assign pat_a[1] = if1.pattern;
    assign sig_a[2]  = if2.signature;  assign pat_a[2] = if2.pattern;

    function automatic int np(input int idx);
        return (idx == 0) ? 1 : (idx == 1) ? 3 : 32;
    endfunction

    // k-th applied pattern: 0 first, then the x^5+x^3+1 sequence from seed 1.
    function automatic logic [4:0] m_pat(input int k);
        logic [4:0] p;
        p = 5'd0;
        for (int i = 0; i < k; i++) p = (p == 5'd0) ? 5'd1 : {p[3:0], p[4] ^ p[2]};
        return p;
    endfunction

    // c17 truth from its gate equations; returns {o23, o22}.
    function automatic logic [1:0] m_c17(input logic [4:0] p);
        logic g1, g2, g3, g6, g7, n10, n11, n16, n19;
        {g7, g6, g3, g2, g1} = p;
        n10 = !(g1 && g3);
        n11 = !(g3 && g6);
        n16 = !(g2 && n11);
        n19 = !(n11 && g7);
        return {!(n16 && n19), !(n10 && n16)};
    endfunction

    function automatic logic [7:0] m_sig(input int n);
        logic [7:0] m;
        logic       fb;
        m = 8'h00;
        for (int k = 0; k < n; k++) begin
            fb = m[7] ^ m[5] ^ m[4] ^ m[3];
            m  = {m[6:0], fb} ^ {6'b0, m_c17(m_pat(k))};
        end
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One run on instance idx; abort_at = RUN cycle (1-based) carrying abort, 0 for none.
    task automatic run(input int idx, input logic [7:0] golden, input int abort_at);
        int         n;
        int         distinct;
        bit         seen [32];
        bit         pats_ok;
        bit         done_seen;
        logic [7:0] exp_sig;
        n         = np(idx);
        distinct  = 0;
        pats_ok   = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 32; i++) seen[i] = 1'b0;
        tick();
        start_a[idx] = 1'b1;
        gold_a[idx]  = golden;
        tick();
        start_a[idx] = 1'b0;
        gold_a[idx]  = 8'($urandom);
        chk("start_busy", 32'(busy_a[idx]), 32'd1);
        chk("start_pat",  32'(pat_a[idx]),  32'd0);
        chk("start_sig",  32'(sig_a[idx]),  32'd0);
        chk("start_pass", 32'(pass_a[idx]), 32'd0);
        for (int c = 1; c <= n; c++) begin
            if (pat_a[idx] !== m_pat(c - 1)) pats_ok = 1'b0;
            if (!seen[pat_a[idx]]) begin
                seen[pat_a[idx]] = 1'b1;
                distinct++;
            end
            if (done_a[idx]) done_seen = 1'b1;
            if (c == abort_at) begin
                abort_a[idx] = 1'b1;
                tick();
                abort_a[idx] = 1'b0;
                chk("abort_busy", 32'(busy_a[idx]), 32'd0);
                for (int w = 0; w < 40; w++) begin
                    if (done_a[idx]) done_seen = 1'b1;
                    tick();
                end
                chk("abort_nodone", 32'(done_seen),   32'd0);
                chk("abort_pass",   32'(pass_a[idx]), 32'd0);
                chk("abort_sig",    32'(sig_a[idx]),  32'(m_sig(c - 1)));
                chk("abort_idle",   32'(busy_a[idx]), 32'd0);
                return;
            end
            tick();
        end
        exp_sig = m_sig(n);
        chk("cmp_busy", 32'(busy_a[idx]), 32'd1);
        if (done_a[idx]) done_seen = 1'b1;
        tick();
        chk("done_pulse", 32'(done_a[idx]), 32'd1);
        chk("done_early", 32'(done_seen),   32'd0);
        chk("done_busy",  32'(busy_a[idx]), 32'd0);
        chk("final_sig",  32'(sig_a[idx]),  32'(exp_sig));
        chk("final_pass", 32'(pass_a[idx]), 32'(golden == exp_sig));
        chk("pat_seq",    32'(pats_ok),     32'd1);
        if (n == 32) chk("distinct32", 32'(distinct), 32'd32);
        tick();
        chk("done_1cyc",  32'(done_a[idx]), 32'd0);
        chk("pass_hold",  32'(pass_a[idx]), 32'(golden == exp_sig));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        int ab;
        logic [7:0] g;
        for (int i = 0; i < 3; i++) begin
            start_a[i] = 1'b0;
            abort_a[i] = 1'b0;
            gold_a[i]  = 8'h00;
        end

        #2;
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", 32'(busy_a[i]), 32'd0);
            chk("rst_done", 32'(done_a[i]), 32'd0);
            chk("rst_pass", 32'(pass_a[i]), 32'd0);
            chk("rst_sig",  32'(sig_a[i]),  32'd0);
            chk("rst_pat",  32'(pat_a[i]),  32'd0);
        end
        #10 rst_n = 1'b1;

        chk("model_n3", 32'(m_sig(3)), 32'h03);
        run(0, 8'h00, 0);
        run(0, 8'h01, 0);
        run(1, 8'h03, 0);
        run(2, m_sig(32), 0);
        run(2, m_sig(32), 5);

        start_a[1] = 1'b1;
        abort_a[1] = 1'b1;
        tick();
        tick();
        start_a[1] = 1'b0;
        abort_a[1] = 1'b0;
        chk("start_abort_idle", 32'(busy_a[1]), 32'd0);

        start_a[0] = 1'b1;
        gold_a[0]  = 8'h00;
        tick();
        start_a[0] = 1'b0;
        tick();
        tick();
        chk("sid_done", 32'(done_a[0]), 32'd1);
        start_a[0] = 1'b1;
        tick();
        chk("sid_ignored", 32'(busy_a[0]), 32'd0);
        tick();
        start_a[0] = 1'b0;
        chk("sid_accept", 32'(busy_a[0]), 32'd1);
        for (int w = 0; w < 4; w++) tick();
        chk("sid_pass", 32'(pass_a[0]), 32'd1);

        start_a[2] = 1'b1;
        gold_a[2]  = 8'h5A;
        tick();
        start_a[2] = 1'b0;
        for (int w = 0; w < 5; w++) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_busy",  32'(busy_a[2]), 32'd0);
        chk("mrst_sig",   32'(sig_a[2]),  32'd0);
        chk("mrst_pat",   32'(pat_a[2]),  32'd0);
        chk("mrst_done",  32'(done_a[2]), 32'd0);
        chk("mrst_pass0", 32'(pass_a[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(2, m_sig(32), 0);

        for (int r = 0; r < 12; r++) begin
            idx = $urandom_range(0, 2);
            g   = ($urandom_range(0, 1) == 1) ? m_sig(np(idx)) : 8'($urandom);
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, np(idx)) : 0;
            for (int w = $urandom_range(0, 3); w > 0; w--) tick();
            run(idx, g, ab);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
